// File: rtl/alu_pkg.sv
// Shared definitions for the 8-bit ALU slice and its multi-byte sequencer:
// opcode encodings, sequencer state encoding and opcode classification.
package alu_pkg;

    localparam logic [2:0] OP_ADD  = 3'b000;  // a + b + c_in
    localparam logic [2:0] OP_SUB  = 3'b001;  // a + ~b + c_in
    localparam logic [2:0] OP_RSUB = 3'b010;  // b + ~a + ~c_in
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_AND  = 3'b100;
    localparam logic [2:0] OP_ANDN = 3'b101;  // a & ~b
    localparam logic [2:0] OP_XOR  = 3'b110;
    localparam logic [2:0] OP_XNOR = 3'b111;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } seq_state_t;

    function automatic logic is_arith(input logic [2:0] oper);
        return oper <= OP_RSUB;
    endfunction

endpackage

// File: rtl/alu_seq_ctrl.sv
// Drives an external 8-bit ALU one byte per cycle (LSB first) to execute one
// NBYTES-wide operation, chaining the carry, and returns the wide result.
module alu_seq_ctrl
    import alu_pkg::*;
#(
    parameter int NBYTES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic [2:0]            req_oper,
    input  logic [8*NBYTES-1:0]   req_a,
    input  logic [8*NBYTES-1:0]   req_b,
    input  logic                  req_cin,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [8*NBYTES-1:0]   rsp_sum,
    output logic                  rsp_cout,
    output logic                  rsp_zero,
    output logic [2:0]            alu_oper,
    output logic [7:0]            alu_a,
    output logic [7:0]            alu_b,
    output logic                  alu_cin,
    input  logic [7:0]            alu_sum,
    input  logic                  alu_cout
);

    localparam int W     = 8 * NBYTES;
    localparam int IDX_W = $clog2(NBYTES);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NBYTES - 1);

    seq_state_t       state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [2:0]       oper_q, oper_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             cin_q, cin_d;
    logic [W-1:0]     result_q, result_d;
    logic             carry_q, carry_d;
    logic             zero_q, zero_d;

    // ALU drive depends only on registered state, so the external ALU's
    // combinational return path never loops back into this block.
    always_comb begin
        alu_oper = '0;
        alu_a    = '0;
        alu_b    = '0;
        alu_cin  = 1'b0;
        if (state_q == ST_RUN) begin
            alu_oper = oper_q;
            alu_a    = a_q[8*idx_q +: 8];
            alu_b    = b_q[8*idx_q +: 8];
            if (!is_arith(oper_q)) begin
                alu_cin = 1'b0;
            end else if (idx_q == '0) begin
                alu_cin = cin_q;
            end else if (oper_q == OP_RSUB) begin
                // The ALU inverts c_in for RSUB, so hand it the inverted carry.
                alu_cin = ~carry_q;
            end else begin
                alu_cin = carry_q;
            end
        end
    end

    // NOTE: every signal gets a default before the case so no path leaves it
    // unassigned; a missing default here would infer a latch.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        oper_d    = oper_q;
        a_d       = a_q;
        b_d       = b_q;
        cin_d     = cin_q;
        result_d  = result_q;
        carry_d   = carry_q;
        zero_d    = zero_q;
        req_ready = 1'b0;
        rsp_valid = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) begin
                    oper_d   = req_oper;
                    a_d      = req_a;
                    b_d      = req_b;
                    cin_d    = req_cin;
                    idx_d    = '0;
                    result_d = '0;
                    carry_d  = 1'b0;
                    zero_d   = 1'b0;
                    state_d  = ST_RUN;
                end
            end
            ST_RUN: begin
                result_d[8*idx_q +: 8] = alu_sum;
                carry_d = is_arith(oper_q) ? alu_cout : 1'b0;
                if (idx_q == IDX_LAST) begin
                    zero_d  = (result_d == '0);
                    state_d = ST_DONE;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            ST_DONE: begin
                rsp_valid = 1'b1;
                if (rsp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples
    // the pre-edge values; blocking here would create order-dependent races.
    // NOTE: operand and result registers are reset too, so an aborted
    // operation can never leak bytes or carry into the next one.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            idx_q    <= '0;
            oper_q   <= '0;
            a_q      <= '0;
            b_q      <= '0;
            cin_q    <= 1'b0;
            result_q <= '0;
            carry_q  <= 1'b0;
            zero_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            oper_q   <= oper_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            result_q <= result_d;
            carry_q  <= carry_d;
            zero_q   <= zero_d;
        end
    end

    assign rsp_sum  = result_q;
    assign rsp_cout = carry_q;
    assign rsp_zero = zero_q;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Self-checking bench for alu_seq_ctrl: behavioural 8-bit ALU, wide-arithmetic
// reference model, per-cycle compare process and directed scenarios.
module tb_alu_seq_ctrl;
    import alu_pkg::*;

    localparam int NBYTES = 4;
    localparam int W      = 8 * NBYTES;

    typedef logic [W:0] wide1_t;

    logic         clk;
    logic         rst_n;
    logic         req_valid;
    logic         req_ready;
    logic [2:0]   req_oper;
    logic [W-1:0] req_a;
    logic [W-1:0] req_b;
    logic         req_cin;
    logic         rsp_valid;
    logic         rsp_ready;
    logic [W-1:0] rsp_sum;
    logic         rsp_cout;
    logic         rsp_zero;
    logic [2:0]   alu_oper;
    logic [7:0]   alu_a;
    logic [7:0]   alu_b;
    logic         alu_cin;
    logic [7:0]   alu_sum;
    logic         alu_cout;
    logic [8:0]   alu_t;

    int n_cmp = 0;
    int n_err = 0;

    alu_seq_ctrl #(.NBYTES(NBYTES)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_oper  (req_oper),
        .req_a     (req_a),
        .req_b     (req_b),
        .req_cin   (req_cin),
        .rsp_valid (rsp_valid),
        .rsp_ready (rsp_ready),
        .rsp_sum   (rsp_sum),
        .rsp_cout  (rsp_cout),
        .rsp_zero  (rsp_zero),
        .alu_oper  (alu_oper),
        .alu_a     (alu_a),
        .alu_b     (alu_b),
        .alu_cin   (alu_cin),
        .alu_sum   (alu_sum),
        .alu_cout  (alu_cout)
    );

    // Team 8-bit ALU slice, behavioural.
    always_comb begin
        case (alu_oper)
            OP_ADD:  alu_t = {1'b0, alu_a} + {1'b0, alu_b} + {8'd0, alu_cin};
            OP_SUB:  alu_t = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'd0, alu_cin};
            OP_RSUB: alu_t = {1'b0, alu_b} + {1'b0, ~alu_a} + {8'd0, ~alu_cin};
            OP_OR:   alu_t = {1'b0, alu_a | alu_b};
            OP_AND:  alu_t = {1'b0, alu_a & alu_b};
            OP_ANDN: alu_t = {1'b0, alu_a & ~alu_b};
            OP_XOR:  alu_t = {1'b0, alu_a ^ alu_b};
            default: alu_t = {1'b0, ~(alu_a ^ alu_b)};
        endcase
    end
    assign alu_sum  = alu_t[7:0];
    assign alu_cout = alu_t[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Wide reference: {final carry, result} straight from the opcode's meaning.
    function automatic wide1_t model(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic c);
        case (op)
            OP_ADD:  return {1'b0, a} + {1'b0, b} + wide1_t'(c);
            OP_SUB:  return {1'b0, a} + {1'b0, ~b} + wide1_t'(c);
            OP_RSUB: return {1'b0, b} + {1'b0, ~a} + wide1_t'(!c);
            OP_OR:   return {1'b0, a | b};
            OP_AND:  return {1'b0, a & b};
            OP_ANDN: return {1'b0, a & ~b};
            OP_XOR:  return {1'b0, a ^ b};
            default: return {1'b0, ~(a ^ b)};
        endcase
    endfunction

    // Carry the ALU must receive for byte k: carry out of the low k bytes.
    function automatic logic exp_cin(input logic [2:0] op, input logic [W-1:0] a,
                                     input logic [W-1:0] b, input logic c, input int k);
        wide1_t x, y, mask, s;
        logic   ci;
        if (op > OP_RSUB) return 1'b0;
        if (k == 0) return c;
        x  = {1'b0, (op == OP_RSUB) ? b : a};
        y  = {1'b0, (op == OP_ADD) ? b : ((op == OP_SUB) ? ~b : ~a)};
        ci = (op == OP_RSUB) ? !c : c;
        mask = (wide1_t'(1) << (8 * k)) - wide1_t'(1);
        s = (x & mask) + (y & mask) + wide1_t'(ci);
        return (op == OP_RSUB) ? !s[8*k] : s[8*k];
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Bench-side view of the transaction: accepted operands and timing.
    int           cyc;
    int           c0;
    logic         in_flight;
    logic [2:0]   m_op;
    logic [W-1:0] m_a;
    logic [W-1:0] m_b;
    logic         m_cin;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            in_flight <= 1'b0;
            cyc       <= 0;
            c0        <= 0;
        end else begin
            cyc <= cyc + 1;
            if (!in_flight && req_valid) begin
                in_flight <= 1'b1;
                c0        <= cyc + 1;
                m_op      <= req_oper;
                m_a       <= req_a;
                m_b       <= req_b;
                m_cin     <= req_cin;
            end else if (in_flight && (cyc - c0) >= NBYTES && rsp_ready) begin
                in_flight <= 1'b0;
            end
        end
    end

    // Per-cycle comparison against the model.
    always @(negedge clk) begin
        if (rst_n) begin
            int     d;
            logic   ev;
            wide1_t r;
            d  = cyc - c0;
            ev = in_flight && (d >= NBYTES);
            r  = model(m_op, m_a, m_b, m_cin);
            check("req_ready", req_ready, !in_flight);
            check("rsp_valid", rsp_valid, ev);
            if (ev) begin
                check("rsp_sum", rsp_sum, r[W-1:0]);
                check("rsp_cout", rsp_cout, r[W]);
                check("rsp_zero", rsp_zero, r[W-1:0] == '0);
            end
            if (in_flight && d < NBYTES) begin
                check("alu_oper", alu_oper, m_op);
                check("alu_a", alu_a, m_a[8*d +: 8]);
                check("alu_b", alu_b, m_b[8*d +: 8]);
                check("alu_cin", alu_cin, exp_cin(m_op, m_a, m_b, m_cin, d));
            end else begin
                check("alu_idle", {alu_oper, alu_a, alu_b, alu_cin}, '0);
            end
        end
    end

    task automatic issue(input logic [2:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b, input logic c);
        int n;
        n = 0;
        while (in_flight && n < 100) begin
            @(negedge clk);
            n++;
        end
        req_oper  = op;
        req_a     = a;
        req_b     = b;
        req_cin   = c;
        req_valid = 1'b1;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!in_flight && n < 100);
        if (!in_flight) check("accept_timeout", 0, 1);
        // Scramble the request bus: the block must use only the accepted values.
        req_valid = 1'b0;
        req_a     = $urandom;
        req_b     = $urandom;
        req_oper  = 3'($urandom);
        req_cin   = 1'($urandom);
    endtask

    task automatic finish_op();
        int n;
        n = 0;
        while (in_flight && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (in_flight) check("finish_timeout", 0, 1);
    endtask

    typedef struct {
        logic [2:0]   op;
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         c;
    } vec_t;

    vec_t vecs[10];

    initial begin
        int n;
        rst_n     = 1'b0;
        req_valid = 1'b0;
        req_oper  = '0;
        req_a     = '0;
        req_b     = '0;
        req_cin   = 1'b0;
        rsp_ready = 1'b1;

        // Hand-computed values pinning the reference model.
        check("pin_add_ff", model(OP_ADD, 32'h000000FF, 32'h00000001, 1'b0), 33'h0_00000100);
        check("pin_add_wrap", model(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0), 33'h1_00000000);
        check("pin_sub", model(OP_SUB, 32'h00000100, 32'h00000001, 1'b1), 33'h1_000000FF);
        check("pin_rsub", model(OP_RSUB, 32'h00000001, 32'h00000100, 1'b0), 33'h1_000000FF);
        check("pin_xor", model(OP_XOR, 32'h12345678, 32'hFFFF0000, 1'b1), 33'h0_EDCB5678);
        check("pin_cin_add_b1", exp_cin(OP_ADD, 32'h000000FF, 32'h00000001, 1'b0, 1), 1'b1);

        repeat (2) @(negedge clk);
        check("reset_outputs", {req_ready, rsp_valid, rsp_cout, rsp_zero, rsp_sum,
                                alu_oper, alu_a, alu_b, alu_cin}, {1'b1, 55'd0});
        #2 rst_n = 1'b1;
        @(negedge clk);

        // ADD with latency measurement
        issue(OP_ADD, 32'h000000FF, 32'h00000001, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("latency", n + 1, NBYTES + 1);
        check("add_ff_sum", rsp_sum, 32'h00000100);
        finish_op();

        issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b0);
        finish_op();
        issue(OP_SUB, 32'h00000100, 32'h00000001, 1'b1);
        finish_op();
        issue(OP_RSUB, 32'h00000001, 32'h00000100, 1'b0);
        finish_op();
        issue(OP_XOR, 32'h12345678, 32'hFFFF0000, 1'b1);
        finish_op();

        // Back-to-back table at minimum issue interval
        vecs[0] = '{OP_ADD,  32'h12345678, 32'h87654321, 1'b1};
        vecs[1] = '{OP_SUB,  32'h00000005, 32'h00000010, 1'b1};
        vecs[2] = '{OP_SUB,  32'h80000000, 32'h00000001, 1'b0};
        vecs[3] = '{OP_RSUB, 32'h00000010, 32'h00000005, 1'b1};
        vecs[4] = '{OP_RSUB, 32'hDEADBEEF, 32'hDEADBEEF, 1'b0};
        vecs[5] = '{OP_OR,   32'hF0F00000, 32'h0000F0F1, 1'b1};
        vecs[6] = '{OP_AND,  32'hFF00FF00, 32'h0F0F0F0F, 1'b1};
        vecs[7] = '{OP_ANDN, 32'hFFFFFFFF, 32'h00FF00FF, 1'b0};
        vecs[8] = '{OP_XNOR, 32'hA5A5A5A5, 32'h5A5A5A5A, 1'b1};
        vecs[9] = '{OP_AND,  32'hAAAAAAAA, 32'h55555555, 1'b0};
        for (int i = 0; i < 10; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].c);
        end
        finish_op();

        // Backpressure, with a second request pending during RUN
        rsp_ready = 1'b0;
        issue(OP_ADD, 32'h11111111, 32'h22222222, 1'b0);
        @(negedge clk);
        req_oper  = OP_SUB;
        req_a     = 32'h00000050;
        req_b     = 32'h00000020;
        req_cin   = 1'b1;
        req_valid = 1'b1;
        n = 0;
        while (!(in_flight && (cyc - c0) >= NBYTES) && n < 20) begin
            @(negedge clk);
            n++;
        end
        for (int i = 0; i < 3; i++) begin
            check("bp_sum_held", rsp_sum, 32'h33333333);
            check("bp_req_ready", req_ready, 1'b0);
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        n = 0;
        while (in_flight && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("bp_idle_after_hs", req_ready, 1'b1);
        n = 0;
        while (!in_flight && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = 1'b0;
        check("bp_second_accepted", m_a, 32'h00000050);
        finish_op();
        check("bp_second_sum", model(OP_SUB, 32'h50, 32'h20, 1'b1), 33'h1_00000030);

        // Asynchronous reset at idx 2, then a clean operation
        issue(OP_ADD, 32'hFFFFFFFF, 32'h00000001, 1'b1);
        repeat (2) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        check("midrun_reset", {req_ready, rsp_valid, rsp_cout, rsp_zero, rsp_sum,
                               alu_oper, alu_a, alu_b, alu_cin}, {1'b1, 55'd0});
        @(negedge clk);
        #2 rst_n = 1'b1;
        issue(OP_ADD, 32'h00000000, 32'h00000000, 1'b0);
        n = 0;
        while (!rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("post_reset_sum", rsp_sum, 32'h00000000);
        check("post_reset_cout", rsp_cout, 1'b0);
        check("post_reset_zero", rsp_zero, 1'b1);
        finish_op();

        repeat (3) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

endmodule
